// File: rtl/dff_pkg.sv
// Shared constants and width helper for the dff_pipe delay line.
package dff_pkg;

    localparam int unsigned DFF_INIT_DEFAULT = 0;

    // Width of a field able to index/count n things; never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH-bit data register plus valid bit with enable and flush.
module dff_stage
    import dff_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  INIT  = WIDTH'(DFF_INIT_DEFAULT)
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;

    // Flush beats advance; otherwise hold.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (clr) begin
            data_d = INIT;
            vld_d  = 1'b0;
        end else if (en) begin
            data_d = d;
            vld_d  = d_vld;
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= INIT;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q     = data_q;
    assign q_vld = vld_q;

endmodule

// File: rtl/dff_pipe.sv
// Stallable, flushable DEPTH-stage delay line with occupancy count and a
// combinational intermediate tap.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter int unsigned       DEPTH = 4,
    parameter logic [WIDTH-1:0]  INIT  = WIDTH'(DFF_INIT_DEFAULT),
    localparam int unsigned      TW    = width_of(DEPTH),
    localparam int unsigned      FW    = width_of(DEPTH + 1)
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    output logic [WIDTH-1:0] tap_q,
    output logic [FW-1:0]    fill
);

    logic [WIDTH-1:0] s_in [DEPTH];
    logic [WIDTH-1:0] s    [DEPTH];
    logic [DEPTH-1:0] v_in;
    logic [DEPTH-1:0] v;
    logic [FW-1:0]    fill_d, fill_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign s_in[i] = d;
            assign v_in[i] = d_vld;
        end else begin : g_link
            assign s_in[i] = s[i-1];
            assign v_in[i] = v[i-1];
        end

        dff_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .c     (c),
            .rst_n (rst_n),
            .en    (en),
            .clr   (clr),
            .d     (s_in[i]),
            .d_vld (v_in[i]),
            .q     (s[i]),
            .q_vld (v[i])
        );
    end

    // Occupancy tracked incrementally: one in, one out per enabled edge.
    always_comb begin
        fill_d = fill_q;
        if (clr) begin
            fill_d = '0;
        end else if (en) begin
            fill_d = fill_q + FW'(d_vld) - FW'(v[DEPTH-1]);
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    // Out-of-range tap selections fall through to INIT.
    always_comb begin
        tap_q = INIT;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TW'(i)) begin
                tap_q = s[i];
            end
        end
    end

    assign q     = s[DEPTH-1];
    assign q_vld = v[DEPTH-1];
    assign fill  = fill_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: DEPTH=4 main instance plus a DEPTH=3 instance
// sharing the same stimulus for the out-of-range tap case.
module tb_dff_pipe;

    logic       c = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] d = 8'h00;
    logic       d_vld = 1'b0;
    logic [1:0] tap_sel = 2'd0;

    logic [7:0] q, tap_q, q3, tap_q3;
    logic       q_vld, q_vld3;
    logic [2:0] fill;
    logic [1:0] fill3;

    int n_vec = 0;
    int n_err = 0;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5)) u_dut (
        .c(c), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .d_vld(d_vld),
        .tap_sel(tap_sel), .q(q), .q_vld(q_vld), .tap_q(tap_q), .fill(fill)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5)) u_dut3 (
        .c(c), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .d_vld(d_vld),
        .tap_sel(tap_sel), .q(q3), .q_vld(q_vld3), .tap_q(tap_q3), .fill(fill3)
    );

    always #5 c = ~c;

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge c);
        #1;
        n_vec++; if (q !== 8'hA5) begin n_err++; $display("FAIL reset_q got %h want a5", q); end
        n_vec++; if (q_vld !== 1'b0) begin n_err++; $display("FAIL reset_q_vld got %b want 0", q_vld); end
        n_vec++; if (fill !== 3'd0) begin n_err++; $display("FAIL reset_fill got %0d want 0", fill); end
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            n_vec++; if (tap_q !== 8'hA5) begin n_err++; $display("FAIL reset_tap%0d got %h want a5", i, tap_q); end
        end
        n_vec++; if (tap_q3 !== 8'hA5) begin n_err++; $display("FAIL reset_tap3_d3 got %h want a5", tap_q3); end
        tap_sel = 2'd0;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic [7:0] exp_q    [8] = '{8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        logic       exp_vld  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [2:0] exp_fill [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
        en = 1'b1;
        d_vld = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d = 8'(k + 1);
            tick();
            n_vec++; if (q !== exp_q[k]) begin n_err++; $display("FAIL latency_q edge%0d got %h want %h", k + 1, q, exp_q[k]); end
            n_vec++; if (q_vld !== exp_vld[k]) begin n_err++; $display("FAIL latency_vld edge%0d got %b want %b", k + 1, q_vld, exp_vld[k]); end
            n_vec++; if (fill !== exp_fill[k]) begin n_err++; $display("FAIL latency_fill edge%0d got %0d want %0d", k + 1, fill, exp_fill[k]); end
        end
    endtask

    task automatic test_flush();
        n_vec++; if (fill !== 3'd4) begin n_err++; $display("FAIL flush_pre_fill got %0d want 4", fill); end
        clr = 1'b1; en = 1'b1; d = 8'hFF; d_vld = 1'b1;
        tick();
        n_vec++; if (fill !== 3'd0) begin n_err++; $display("FAIL flush_fill got %0d want 0", fill); end
        n_vec++; if (q_vld !== 1'b0) begin n_err++; $display("FAIL flush_vld got %b want 0", q_vld); end
        n_vec++; if (q !== 8'hA5) begin n_err++; $display("FAIL flush_q got %h want a5", q); end
        clr = 1'b0; d = 8'h00; d_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++; if (q_vld !== 1'b0 || q === 8'hFF) begin n_err++; $display("FAIL flush_drain edge%0d got q=%h vld=%b want no ff, vld 0", k, q, q_vld); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_q    [4] = '{8'h00, 8'h11, 8'h22, 8'h00};
        logic       exp_vld  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0] exp_fill [4] = '{3'd2, 3'd2, 3'd1, 3'd0};
        en = 1'b1; d_vld = 1'b1;
        d = 8'h11; tick();
        d = 8'h22; tick();
        en = 1'b0; d = 8'h33; tap_sel = 2'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (q !== 8'h00 || q_vld !== 1'b0 || fill !== 3'd2 || tap_q !== 8'h11) begin
                n_err++; $display("FAIL stall_hold cyc%0d got q=%h vld=%b fill=%0d tap=%h want 00 0 2 11", k, q, q_vld, fill, tap_q);
            end
        end
        en = 1'b1; d_vld = 1'b0; d = 8'h00; tap_sel = 2'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++; if (q !== exp_q[k] || q_vld !== exp_vld[k] || fill !== exp_fill[k]) begin
                n_err++; $display("FAIL stall_resume edge%0d got q=%h vld=%b fill=%0d want %h %b %0d",
                                  k + 3, q, q_vld, fill, exp_q[k], exp_vld[k], exp_fill[k]);
            end
        end
    endtask

    task automatic test_bubbles();
        logic       in_vld   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] in_d     [8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] exp_q    [8] = '{8'h00, 8'h00, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h00};
        logic       exp_vld  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0] exp_fill [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d = in_d[k]; d_vld = in_vld[k];
            tick();
            n_vec++; if (q !== exp_q[k] || q_vld !== exp_vld[k] || fill !== exp_fill[k]) begin
                n_err++; $display("FAIL bubbles edge%0d got q=%h vld=%b fill=%0d want %h %b %0d",
                                  k + 1, q, q_vld, fill, exp_q[k], exp_vld[k], exp_fill[k]);
            end
        end
    endtask

    task automatic test_tap();
        logic [7:0] exp_tap [4] = '{8'h09, 8'h08, 8'h07, 8'h00};
        en = 1'b1; d_vld = 1'b1;
        d = 8'h07; tick();
        d = 8'h08; tick();
        d = 8'h09; tick();
        en = 1'b0; d_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            n_vec++; if (tap_q !== exp_tap[i]) begin n_err++; $display("FAIL tap_sel%0d got %h want %h", i, tap_q, exp_tap[i]); end
        end
        tap_sel = 2'd2; #1;
        n_vec++; if (tap_q3 !== 8'h07) begin n_err++; $display("FAIL tap_d3_sel2 got %h want 07", tap_q3); end
        tap_sel = 2'd3; #1;
        n_vec++; if (tap_q3 !== 8'hA5) begin n_err++; $display("FAIL tap_d3_sel3 got %h want a5", tap_q3); end
        tap_sel = 2'd0;
    endtask

    task automatic test_async_reset();
        n_vec++; if (fill !== 3'd3) begin n_err++; $display("FAIL areset_pre_fill got %0d want 3", fill); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (q !== 8'hA5 || q_vld !== 1'b0 || fill !== 3'd0 || tap_q !== 8'hA5) begin
            n_err++; $display("FAIL areset_now got q=%h vld=%b fill=%0d tap=%h want a5 0 0 a5", q, q_vld, fill, tap_q);
        end
        n_vec++; if (fill3 !== 2'd0 || q_vld3 !== 1'b0) begin
            n_err++; $display("FAIL areset_d3 got fill=%0d vld=%b want 0 0", fill3, q_vld3);
        end
        rst_n = 1'b1;
        tick();
        n_vec++; if (q !== 8'hA5 || q_vld !== 1'b0 || fill !== 3'd0) begin
            n_err++; $display("FAIL areset_after got q=%h vld=%b fill=%0d want a5 0 0", q, q_vld, fill);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_flush();
        test_stall();
        test_bubbles();
        test_tap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
